// File: rtl/safe_pin_sender.sv
// Keypad initiator for the safe: pulses safe reset, sends a 16-bit PIN as four nibbles, then waits for unlock.
// Optional build macro SAFE_PIN_SENDER_SWEEP_EN turns a failed attempt into an incrementing code search.
module safe_pin_sender #(
  parameter int GAP_CYCLES   = 2,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [15:0] code_i,
  input  logic        unlocked_i,
  output logic        safe_reset_o,
  output logic [3:0]  din_o,
  output logic        din_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        success_o,
  output logic        fail_o,
  output logic [15:0] found_code_o
);

  // state | meaning
  // IDLE  | waiting for start
  // CLEAR | safe reset pulse
  // SEND  | one digit strobe
  // GAP   | idle cycles between digits
  // WAIT  | watching unlocked, bounded by RESP_TIMEOUT
  // DONE  | done pulse, result flags valid
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEND, S_GAP, S_WAIT, S_DONE
  } state_t;

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int WW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESP_TIMEOUT - 1);

  state_t        state_q;
  logic [15:0]   code_q;
  logic [1:0]    idx_q;
  logic [GW-1:0] gap_cnt_q;
  logic [WW-1:0] wait_cnt_q;
  logic          safe_reset_q;
  logic [3:0]    din_q;
  logic          din_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          success_q;
  logic          fail_q;

`ifdef SAFE_PIN_SENDER_SWEEP_EN
  logic [15:0] start_code_q;
  logic [15:0] code_inc_d;
  assign code_inc_d = code_q + 16'd1;
`endif

  function automatic logic [3:0] nib(input logic [15:0] c, input logic [1:0] i);
    case (i)
      2'd0:    nib = c[15:12];
      2'd1:    nib = c[11:8];
      2'd2:    nib = c[7:4];
      default: nib = c[3:0];
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      code_q       <= 16'h0;
      idx_q        <= 2'd0;
      gap_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      safe_reset_q <= 1'b0;
      din_q        <= 4'h0;
      din_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      success_q    <= 1'b0;
      fail_q       <= 1'b0;
`ifdef SAFE_PIN_SENDER_SWEEP_EN
      start_code_q <= 16'h0;
`endif
    end else begin
      safe_reset_q <= 1'b0;
      din_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            code_q       <= code_i;
`ifdef SAFE_PIN_SENDER_SWEEP_EN
            start_code_q <= code_i;
`endif
            success_q    <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b1;
            safe_reset_q <= 1'b1;
            state_q      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          idx_q       <= 2'd0;
          din_q       <= nib(code_q, 2'd0);
          din_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (idx_q == 2'd3) begin
            wait_cnt_q <= '0;
            state_q    <= S_WAIT;
          end else if (GAP_CYCLES == 0) begin
            idx_q       <= idx_q + 2'd1;
            din_q       <= nib(code_q, idx_q + 2'd1);
            din_valid_q <= 1'b1;
          end else begin
            // idx advances on leaving SEND so GAP already holds the next digit index
            idx_q     <= idx_q + 2'd1;
            gap_cnt_q <= GAP_LOAD;
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            din_q       <= nib(code_q, idx_q);
            din_valid_q <= 1'b1;
            state_q     <= S_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          if (unlocked_i) begin
            success_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (wait_cnt_q == WAIT_LAST) begin
`ifdef SAFE_PIN_SENDER_SWEEP_EN
            if (code_inc_d == start_code_q) begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              code_q       <= code_inc_d;
              safe_reset_q <= 1'b1;
              state_q      <= S_CLEAR;
            end
`else
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign safe_reset_o = safe_reset_q;
  assign din_o        = din_q;
  assign din_valid_o  = din_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign success_o    = success_q;
  assign fail_o       = fail_q;
  assign found_code_o = code_q;

endmodule

// File: tb/tb_safe_pin_sender.sv
// Bench for safe_pin_sender: behavioural safe (secret c0de, backdoor f00f, lockout otherwise),
// a vector table of whole attempts, plus hand sequences for start-while-busy, mid-run reset and GAP_CYCLES=0.
module tb_safe_pin_sender;
  localparam int TB_GAP = 2;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] code;
  logic        unlocked;
  logic        safe_reset;
  logic [3:0]  din;
  logic        din_valid;
  logic        busy, done, success, fail;
  logic [15:0] found_code;

  logic        start2;
  logic [15:0] code2;
  logic        unlocked2;
  logic        safe_reset2;
  logic [3:0]  din2;
  logic        din_valid2;
  logic        busy2, done2, success2, fail2;
  logic [15:0] found_code2;

  int checks = 0;
  int errors = 0;

  safe_pin_sender #(.GAP_CYCLES(TB_GAP), .RESP_TIMEOUT(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .code_i(code),
    .unlocked_i(unlocked), .safe_reset_o(safe_reset), .din_o(din),
    .din_valid_o(din_valid), .busy_o(busy), .done_o(done),
    .success_o(success), .fail_o(fail), .found_code_o(found_code));

  safe_pin_sender #(.GAP_CYCLES(0), .RESP_TIMEOUT(8)) dut_g0 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start2), .code_i(code2),
    .unlocked_i(unlocked2), .safe_reset_o(safe_reset2), .din_o(din2),
    .din_valid_o(din_valid2), .busy_o(busy2), .done_o(done2),
    .success_o(success2), .fail_o(fail2), .found_code_o(found_code2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural safe: unlocks on c0de or f00f, locks out on any other 4-digit entry
  logic [15:0] sm_entry;
  logic [2:0]  sm_cnt;
  logic        sm_lock;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sm_entry <= 16'h0; sm_cnt <= 3'd0; sm_lock <= 1'b0; unlocked <= 1'b0;
    end else if (safe_reset) begin
      sm_entry <= 16'h0; sm_cnt <= 3'd0; sm_lock <= 1'b0; unlocked <= 1'b0;
    end else if (din_valid && !sm_lock && !unlocked) begin
      sm_entry <= {sm_entry[11:0], din};
      if (sm_cnt == 3'd3) begin
        sm_cnt <= 3'd0;
        if ({sm_entry[11:0], din} == 16'hc0de || {sm_entry[11:0], din} == 16'hf00f)
          unlocked <= 1'b1;
        else
          sm_lock <= 1'b1;
      end else begin
        sm_cnt <= sm_cnt + 3'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int          r_done_cyc, r_strobes, r_resets, r_dones;
  logic [15:0] r_digs;
  logic        r_cyc_ok, r_busy_ok, r_after_ok, r_cleared;

  task automatic run_attempt(input logic [15:0] c, input int inject);
    @(negedge clk);
    start = 1'b1; code = c;
    @(posedge clk); #1;
    start = 1'b0; code = 16'h0;
    r_done_cyc = -1; r_strobes = 0; r_resets = 0; r_dones = 0;
    r_digs = 16'h0; r_cyc_ok = 1'b1; r_busy_ok = 1'b1; r_cleared = 1'b1;
    for (int cyc = 1; cyc <= 400 && r_done_cyc < 0; cyc++) begin
      if (cyc == 1 && (success || fail)) r_cleared = 1'b0;
      if (safe_reset) r_resets++;
      if (din_valid) begin
        if (r_strobes < 4) begin
          r_digs = {r_digs[11:0], din};
          if (cyc != 2 + r_strobes * (TB_GAP + 1)) r_cyc_ok = 1'b0;
        end
        r_strobes++;
      end
      if (done) begin
        r_dones++;
        r_done_cyc = cyc;
        if (busy) r_busy_ok = 1'b0;
      end else if (!busy) begin
        r_busy_ok = 1'b0;
      end
      if (cyc == inject) begin start = 1'b1; code = 16'h0000; end
      else begin start = 1'b0; code = 16'h0; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    r_after_ok = !done && !busy;
    if (r_done_cyc < 0) begin
      errors++;
      $display("FAIL attempt_timeout: no done for code %h", c);
    end
  endtask

  typedef struct {
    logic [15:0] code;
    int          done_cyc;
    logic        succ;
    logic        fl;
    logic [15:0] found;
    int          strobes;
    int          resets;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{16'hc0de, 13, 1'b1, 1'b0, 16'hc0de, 4, 1};
`ifdef SAFE_PIN_SENDER_SWEEP_EN
    vecs[1] = '{16'hf00c, 70, 1'b1, 1'b0, 16'hf00f, 16, 4};
`else
    vecs[1] = '{16'h1234, 20, 1'b0, 1'b1, 16'h1234, 4, 1};
`endif
    vecs[2] = '{16'hf00f, 13, 1'b1, 1'b0, 16'hf00f, 4, 1};

    reset_n = 1'b0; start = 1'b0; code = 16'h0; start2 = 1'b0; code2 = 16'h0; unlocked2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {12'h0, safe_reset, din, din_valid, busy, done, success, fail, found_code},
          32'h0);
    check("reset_outs_g0", {12'h0, safe_reset2, din2, din_valid2, busy2, done2, success2, fail2,
          found_code2}, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 3; i++) begin
      run_attempt(vecs[i].code, 0);
      check($sformatf("v%0d_done_cyc", i), 32'(r_done_cyc), 32'(vecs[i].done_cyc));
      check($sformatf("v%0d_success", i), 32'(success), 32'(vecs[i].succ));
      check($sformatf("v%0d_fail", i), 32'(fail), 32'(vecs[i].fl));
      check($sformatf("v%0d_found", i), 32'(found_code), 32'(vecs[i].found));
      check($sformatf("v%0d_strobes", i), 32'(r_strobes), 32'(vecs[i].strobes));
      check($sformatf("v%0d_resets", i), 32'(r_resets), 32'(vecs[i].resets));
      check($sformatf("v%0d_digits", i), 32'(r_digs), 32'(vecs[i].code));
      check($sformatf("v%0d_digit_timing", i), 32'(r_cyc_ok), 32'd1);
      check($sformatf("v%0d_busy", i), 32'(r_busy_ok), 32'd1);
      check($sformatf("v%0d_dones", i), 32'(r_dones), 32'd1);
      check($sformatf("v%0d_after_done", i), 32'(r_after_ok), 32'd1);
      check($sformatf("v%0d_flags_cleared", i), 32'(r_cleared), 32'd1);
      repeat (2) @(posedge clk);
    end
    #1;
    check("success_held", 32'(success), 32'd1);

    // start with code 0000 while busy must be ignored
    run_attempt(16'hf00f, 4);
    check("busy_start_found", 32'(found_code), 32'hf00f);
    check("busy_start_digits", 32'(r_digs), 32'hf00f);
    check("busy_start_done_cyc", 32'(r_done_cyc), 32'd13);
    check("busy_start_dones", 32'(r_dones), 32'd1);
    check("busy_start_success", 32'(success), 32'd1);

    // reset asserted in the GAP after the second digit
    @(negedge clk); start = 1'b1; code = 16'hc0de;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_gap", {30'h0, busy, din_valid}, 32'h2);
    reset_n = 1'b0;
    #1;
    check("mid_reset_outs", {12'h0, safe_reset, din, din_valid, busy, done, success, fail, found_code},
          32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_reset_no_done", 32'(done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run_attempt(16'hc0de, 0);
    check("post_reset_done_cyc", 32'(r_done_cyc), 32'd13);
    check("post_reset_resets", 32'(r_resets), 32'd1);
    check("post_reset_digits", 32'(r_digs), 32'hc0de);
    check("post_reset_timing", 32'(r_cyc_ok), 32'd1);
    check("post_reset_success", 32'(success), 32'd1);

    // GAP_CYCLES=0 instance, safe never unlocks
    begin
      int          d_cyc, n_str;
      logic [15:0] digs;
      logic        consec;
      d_cyc = -1; n_str = 0; digs = 16'h0; consec = 1'b1;
      @(negedge clk); start2 = 1'b1; code2 = 16'h5a3c;
      @(posedge clk); #1; start2 = 1'b0;
      for (int cyc = 1; cyc <= 60 && d_cyc < 0; cyc++) begin
        if (din_valid2) begin
          if (n_str < 4) begin
            digs = {digs[11:0], din2};
            if (cyc != 2 + n_str) consec = 1'b0;
          end
          n_str++;
        end
        if (done2) d_cyc = cyc;
        @(posedge clk); #1;
      end
      check("g0_digits", 32'(digs), 32'h5a3c);
      check("g0_consecutive", 32'(consec), 32'd1);
      check("g0_strobes", 32'(n_str), 32'd4);
      check("g0_done_cyc", 32'(d_cyc), 32'd14);
      check("g0_fail", {30'h0, success2, fail2}, 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
